manch_decoding: RTL

//  Receive-side counterpart of the Manchester line encoder. Recovers the bit stream from rx_manch
//  (bit b = ~b for first half-bit, b for second half; '1' = low->high, '0' = high->low at mid-bit).

---
 rtl/manch_pkg.sv | 57 +++++
 rtl/manch_rx_sync.sv | 74 +++++++
 rtl/manch_decoding.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/manch_pkg.sv
// -----------------------------------------------------------------------------
// manch_pkg
//   Shared definitions for the Manchester line encoder and decoder.
//   - Default line rate and master clock frequency.
//   - Derivation of the per-bit cycle counts and the decoder timing windows
//     (FULLBAUD, HALFBAUD, MIN_HALF, LO_LIM, HI_LIM) as functions, so that a
//     module parameterised with another BAUDRATE/CLK_FREQ gets its own values.
//   - Receiver state encoding.
//   - 3-input majority helper used by the optional glitch filter.
// -----------------------------------------------------------------------------
package manch_pkg;

    localparam int unsigned BAUDRATE_DEF = 32'd115200;
    localparam int unsigned CLK_FREQ_DEF = 32'd18_750_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } manch_state_e;

    // Clock cycles per line bit.
    function automatic int unsigned full_baud(input int unsigned clk_freq,
                                              input int unsigned baudrate);
        return clk_freq / baudrate;
    endfunction

    // Clock cycles per half bit.
    function automatic int unsigned half_baud(input int unsigned clk_freq,
                                              input int unsigned baudrate);
        return full_baud(clk_freq, baudrate) / 32'd2;
    endfunction

    // Shortest legal spacing between two line edges (quarter bit).
    function automatic int unsigned min_half(input int unsigned clk_freq,
                                             input int unsigned baudrate);
        return full_baud(clk_freq, baudrate) / 32'd4;
    endfunction

    // Earliest position of a mid-bit edge relative to the previous one.
    function automatic int unsigned lo_lim(input int unsigned clk_freq,
                                           input int unsigned baudrate);
        return (32'd3 * full_baud(clk_freq, baudrate)) / 32'd4;
    endfunction

    // Latest position of a mid-bit edge relative to the previous one.
    function automatic int unsigned hi_lim(input int unsigned clk_freq,
                                           input int unsigned baudrate);
        return (32'd5 * full_baud(clk_freq, baudrate)) / 32'd4;
    endfunction

    // Majority vote of three samples.
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

endpackage

// File: rtl/manch_rx_sync.sv
// -----------------------------------------------------------------------------
// manch_rx_sync
//   Brings the asynchronous Manchester line into the mclkin domain and
//   produces one-cycle rise/fall strobes of the cleaned line level.
//   Optional build macro: MANCH_DEC_GLITCH_FILTER_EN adds a 3-sample majority
//   filter after the synchroniser (pulses of one cycle are dropped, two cycles
//   of extra latency).
// Ports
//   mclkin     in   clock
//   rst        in   asynchronous active-high reset (all flops to 0, line idles low)
//   rx_manch   in   raw Manchester line
//   line_rise  out  one-cycle strobe: cleaned line went 0->1
//   line_fall  out  one-cycle strobe: cleaned line went 1->0
// -----------------------------------------------------------------------------
module manch_rx_sync
    import manch_pkg::*;
(
    input  logic mclkin,
    input  logic rst,
    input  logic rx_manch,
    output logic line_rise,
    output logic line_fall
);

    logic sync1_r;
    logic sync2_r;
    logic clean_s;
    logic prev_r;

    // Two-flop synchroniser for the asynchronous line.
    always_ff @(posedge mclkin or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= rx_manch;
            sync2_r <= sync1_r;
        end
    end

`ifdef MANCH_DEC_GLITCH_FILTER_EN
    logic [1:0] smp_r;
    logic       filt_r;

    // Majority over the current and two previous synchronised samples; a
    // single-cycle pulse never occupies two of the three taps.
    always_ff @(posedge mclkin or posedge rst) begin
        if (rst) begin
            smp_r  <= 2'b00;
            filt_r <= 1'b0;
        end else begin
            smp_r  <= {smp_r[0], sync2_r};
            filt_r <= maj3({smp_r, sync2_r});
        end
    end

    assign clean_s = filt_r;
`else
    assign clean_s = sync2_r;
`endif

    // Delayed copy of the cleaned level for edge detection.
    always_ff @(posedge mclkin or posedge rst) begin
        if (rst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= clean_s;
        end
    end

    assign line_rise = clean_s & ~prev_r;
    assign line_fall = ~clean_s & prev_r;

endmodule

// File: rtl/manch_decoding.sv
// -----------------------------------------------------------------------------
// manch_decoding
//   Manchester receiver. Locks on the start bit (always 0) of each frame and
//   emits one decoded bit per mid-bit transition as a held UART-style level.
//   Build option: MANCH_DEC_GLITCH_FILTER_EN enables the input majority filter
//   (rx_valid latency 5 cycles instead of 3).
// Parameters
//   BAUDRATE   line bit rate
//   CLK_FREQ   mclkin frequency
// Ports
//   mclkin     in   clock
//   rst        in   asynchronous active-high reset
//   rx_manch   in   Manchester line, asynchronous to mclkin
//   rx         out  decoded bit level, held; 1 when no frame is active
//   rx_valid   out  one-cycle pulse: rx carries a new bit
//   rx_err     out  one-cycle pulse: timing violation, frame aborted
//   rx_active  out  high while a frame is being decoded
// -----------------------------------------------------------------------------
module manch_decoding
    import manch_pkg::*;
#(
    parameter int unsigned BAUDRATE = BAUDRATE_DEF,
    parameter int unsigned CLK_FREQ = CLK_FREQ_DEF
) (
    input  logic mclkin,
    input  logic rst,
    input  logic rx_manch,
    output logic rx,
    output logic rx_valid,
    output logic rx_err,
    output logic rx_active
);

    localparam logic [15:0] MIN_HALF = 16'(min_half(CLK_FREQ, BAUDRATE));
    localparam logic [15:0] LO_LIM   = 16'(lo_lim(CLK_FREQ, BAUDRATE));
    localparam logic [15:0] HI_LIM   = 16'(hi_lim(CLK_FREQ, BAUDRATE));

    logic         line_rise_s;
    logic         line_fall_s;
    logic         edge_s;

    manch_state_e state_r;
    manch_state_e state_s;
    logic [15:0]  cnt_r;
    logic [15:0]  cnt_s;
    logic [15:0]  cnt_inc_s;
    logic         bnd_seen_r;
    logic         bnd_seen_s;
    logic         rx_s;
    logic         valid_s;
    logic         err_s;
    logic         active_s;

    manch_rx_sync u_sync (
        .mclkin    (mclkin),
        .rst       (rst),
        .rx_manch  (rx_manch),
        .line_rise (line_rise_s),
        .line_fall (line_fall_s)
    );

    assign edge_s    = line_rise_s | line_fall_s;
    assign cnt_inc_s = (cnt_r == 16'hFFFF) ? cnt_r : (cnt_r + 16'd1);

    // Next-state and output decode. All window compares use the count held
    // in the register, i.e. the value before this cycle's increment.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_inc_s;
        bnd_seen_s = bnd_seen_r;
        rx_s       = rx;
        valid_s    = 1'b0;
        err_s      = 1'b0;
        active_s   = rx_active;

        case (state_r)
            IDLE: begin
                cnt_s      = 16'd0;
                bnd_seen_s = 1'b0;
                rx_s       = 1'b1;
                active_s   = 1'b0;
                if (line_fall_s) begin
                    // Line was already high: this fall is the start-bit mid-bit.
                    rx_s     = 1'b0;
                    valid_s  = 1'b1;
                    active_s = 1'b1;
                    state_s  = RUN;
                end else if (line_rise_s) begin
                    // Leading edge of the start bit's high first half.
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end

            START: begin
                if (line_fall_s && (cnt_r >= MIN_HALF) && (cnt_r <= LO_LIM)) begin
                    rx_s     = 1'b0;
                    valid_s  = 1'b1;
                    active_s = 1'b1;
                    cnt_s    = 16'd0;
                    state_s  = RUN;
                end else if (line_fall_s || (cnt_r > LO_LIM)) begin
                    err_s    = 1'b1;
                    rx_s     = 1'b1;
                    active_s = 1'b0;
                    cnt_s    = 16'd0;
                    state_s  = IDLE;
                end else begin
                    state_s = START;
                end
            end

            RUN: begin
                if (cnt_r > HI_LIM) begin
                    // No mid-bit within the window: the frame has ended.
                    rx_s       = 1'b1;
                    active_s   = 1'b0;
                    cnt_s      = 16'd0;
                    bnd_seen_s = 1'b0;
                    state_s    = IDLE;
                end else if (edge_s && (cnt_r >= LO_LIM)) begin
                    // Mid-bit edge: the new line level is the bit value.
                    rx_s       = line_rise_s;
                    valid_s    = 1'b1;
                    cnt_s      = 16'd0;
                    bnd_seen_s = 1'b0;
                    state_s    = RUN;
                end else if (edge_s && (cnt_r >= MIN_HALF) && !bnd_seen_r) begin
                    // First bit-boundary edge since the last mid-bit.
                    bnd_seen_s = 1'b1;
                    state_s    = RUN;
                end else if (edge_s) begin
                    // Too close to the anchor, or a second boundary edge.
                    err_s      = 1'b1;
                    rx_s       = 1'b1;
                    active_s   = 1'b0;
                    cnt_s      = 16'd0;
                    bnd_seen_s = 1'b0;
                    state_s    = IDLE;
                end else begin
                    state_s = RUN;
                end
            end

            default: begin
                rx_s       = 1'b1;
                active_s   = 1'b0;
                cnt_s      = 16'd0;
                bnd_seen_s = 1'b0;
                state_s    = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge mclkin or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 16'd0;
            bnd_seen_r <= 1'b0;
            rx         <= 1'b1;
            rx_valid   <= 1'b0;
            rx_err     <= 1'b0;
            rx_active  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bnd_seen_r <= bnd_seen_s;
            rx         <= rx_s;
            rx_valid   <= valid_s;
            rx_err     <= err_s;
            rx_active  <= active_s;
        end
    end

endmodule
